dmem_responder: RTL

//  Data-memory responder for the single-cycle core: the memory side of the DAD/DDT/ReadDDT data port.

---
 rtl/dmem_pkg.sv | 17 +
 rtl/dmem_lane_align.sv | 53 +++++
 rtl/dmem_responder.sv | 139 +++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// Shared encodings for the data-memory responder: access sizes, FSM states, MMIO address.
package dmem_pkg;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;
  localparam logic [1:0] SIZE_X = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_RESP = 2'b10
  } state_t;

  localparam logic [31:0] MMIO_CNT_ADDR = 32'hFFFF_0000;

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational byte-lane steering: byte enables, store merge into the memory word,
// right-justified load extraction and alignment check.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  ofs,
  input  logic [31:0] wdata,
  input  logic [31:0] mem_word,
  output logic [3:0]  be,
  output logic [31:0] st_word,
  output logic [31:0] ld_data,
  output logic        misalign
);

  localparam int NUM_LANES = 4;

  logic [31:0] wrep;
  logic [31:0] shifted;

  always_comb begin
    be       = '0;
    wrep     = wdata;
    ld_data  = '0;
    misalign = 1'b0;
    shifted  = mem_word >> {ofs, 3'b000};
    case (size)
      SIZE_B: begin
        be      = 4'b0001 << ofs;
        wrep    = {4{wdata[7:0]}};
        ld_data = {24'h0, shifted[7:0]};
      end
      SIZE_H: begin
        be       = ofs[1] ? 4'b1100 : 4'b0011;
        wrep     = {2{wdata[15:0]}};
        ld_data  = {16'h0, shifted[15:0]};
        misalign = ofs[0];
      end
      SIZE_W: begin
        be       = 4'b1111;
        ld_data  = mem_word;
        misalign = |ofs;
      end
      default: ;
    endcase
  end

  // Replicated store data lets each lane pick its own byte without a shifter.
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    assign st_word[8*i +: 8] = be[i] ? wrep[8*i +: 8] : mem_word[8*i +: 8];
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one request at a time, WAIT_CYCLES wait states, lane align, error flag.
// Define DMEM_MMIO_EN to map a free-running cycle counter at MMIO_CNT_ADDR (word loads only).
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 1,
  parameter int ADDR_W      = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        ack,
  output logic        err,
  output logic [31:0] rdata
);

  localparam logic [3:0] CNT_LAST = 4'(WAIT_CYCLES - 1);

  state_t state, nxt;
  logic [3:0] cnt;

  logic        r_we;
  logic [1:0]  r_size;
  logic [31:0] r_addr, r_wdata;

  logic        op_we;
  logic [1:0]  op_size;
  logic [31:0] op_addr, op_wdata;

  logic [ADDR_W-1:0] idx;
  logic [31:0] mem [DEPTH_WORDS];
  logic [31:0] mem_word, st_word, ld_data, ld_val;
  logic [3:0]  be;
  logic        misalign, base_err, acc_err, do_acc, do_wr;

  // With no wait states the access lands on the accept edge itself, so use the live request.
  always_comb begin
    if (state == ST_IDLE) begin
      op_we    = we;
      op_size  = size;
      op_addr  = addr;
      op_wdata = wdata;
    end else begin
      op_we    = r_we;
      op_size  = r_size;
      op_addr  = r_addr;
      op_wdata = r_wdata;
    end
  end

  assign idx      = op_addr[ADDR_W+1:2];
  assign mem_word = mem[idx];

  dmem_lane_align u_align (
    .size     (op_size),
    .ofs      (op_addr[1:0]),
    .wdata    (op_wdata),
    .mem_word (mem_word),
    .be       (be),
    .st_word  (st_word),
    .ld_data  (ld_data),
    .misalign (misalign)
  );

  assign base_err = (op_size == SIZE_X) | misalign | (|op_addr[31:ADDR_W+2]);

  always_comb begin
    nxt = ST_IDLE;
    case (state)
      ST_IDLE: nxt = req ? ((WAIT_CYCLES > 0) ? ST_WAIT : ST_RESP) : ST_IDLE;
      ST_WAIT: nxt = (cnt == CNT_LAST) ? ST_RESP : ST_WAIT;
      ST_RESP: nxt = ST_IDLE;
      default: nxt = ST_IDLE;
    endcase
  end

  assign do_acc = (nxt == ST_RESP);

`ifdef DMEM_MMIO_EN
  logic [31:0] cyc_cnt;
  logic        is_mmio;

  assign is_mmio = (op_addr == MMIO_CNT_ADDR);
  assign acc_err = is_mmio ? (op_size != SIZE_W) : base_err;
  assign do_wr   = do_acc & op_we & ~acc_err & ~is_mmio & (|be);
  assign ld_val  = is_mmio ? cyc_cnt : ld_data;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cyc_cnt <= '0;
    else      cyc_cnt <= cyc_cnt + 32'd1;
  end
`else
  assign acc_err = base_err;
  assign do_wr   = do_acc & op_we & ~acc_err & (|be);
  assign ld_val  = ld_data;
`endif

  always_ff @(posedge clk) begin
    if (do_wr) mem[idx] <= st_word;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      busy    <= 1'b0;
      ack     <= 1'b0;
      err     <= 1'b0;
      rdata   <= '0;
      r_we    <= 1'b0;
      r_size  <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else begin
      state <= nxt;
      busy  <= (nxt != ST_IDLE);
      ack   <= do_acc;
      err   <= do_acc & acc_err;
      cnt   <= (state == ST_WAIT && nxt == ST_WAIT) ? cnt + 4'd1 : 4'd0;
      if (do_acc) begin
        if (acc_err)     rdata <= '0;
        else if (!op_we) rdata <= ld_val;
      end
      if (state == ST_IDLE && req) begin
        r_we    <= we;
        r_size  <= size;
        r_addr  <= addr;
        r_wdata <= wdata;
      end
    end
  end

endmodule
